// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexes four BCD digits (MM:SS) onto a 4-digit
// common-anode seven-segment display. One guard cycle blanks the display at
// the start of every slot, and the pair being adjusted blinks in adjust mode.
// Every output comes from a register, so it shows the previous cycle's slot
// and inputs.
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec1,
  input  logic [3:0] sec0,
  input  logic [3:0] min1,
  input  logic [3:0] min0,
  input  logic [1:0] adj,
  input  logic       select,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // Active-low segment patterns for digits 0-9, ordered gfedcba.
  // Codes 10-15 are invalid BCD and show a dash (only segment g lit).
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  logic [REF_W-1:0] r_refresh_cnt;
  logic [1:0]       r_slot;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic [3:0]       w_digit;
  logic [3:0]       w_an_sel;
  logic             w_dp_sel;
  logic             w_adj_on;
  logic             w_guard;
  logic             w_blank;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;
  logic [3:0]       w_an_nxt;

  // Refresh timer: step through REFRESH_DIV cycles, then move to the next digit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh_cnt <= {REF_W{1'b0}};
      r_slot        <= 2'd0;
    end else if (r_refresh_cnt == REF_LAST) begin
      r_refresh_cnt <= {REF_W{1'b0}};
      r_slot        <= r_slot + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + REF_W'(1);
      r_slot        <= r_slot;
    end
  end

  // Blink timer: runs only in adjust mode and is held at zero otherwise, so
  // every adjust session starts with the visible phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= {BLK_W{1'b0}};
      r_blink_phase <= 1'b0;
    end else if (adj == 2'b00) begin
      r_blink_cnt   <= {BLK_W{1'b0}};
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLK_LAST) begin
      r_blink_cnt   <= {BLK_W{1'b0}};
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLK_W'(1);
      r_blink_phase <= r_blink_phase;
    end
  end

  // Choose the digit, anode and decimal point for the current slot, then apply guard/blink blanking.
  always_comb begin
    w_digit  = 4'd0;
    w_an_sel = 4'b1111;
    w_dp_sel = 1'b1;
    case (r_slot)
      2'd0: begin
        w_digit  = sec1;
        w_an_sel = 4'b1110;
      end
      2'd1: begin
        w_digit  = sec0;
        w_an_sel = 4'b1101;
      end
      2'd2: begin
        w_digit  = min1;
        w_an_sel = 4'b1011;
        w_dp_sel = 1'b0;
      end
      2'd3: begin
        w_digit  = min0;
        w_an_sel = 4'b0111;
      end
      default: begin
        w_digit  = 4'd0;
        w_an_sel = 4'b1111;
        w_dp_sel = 1'b1;
      end
    endcase

    w_adj_on = (adj != 2'b00);
    w_guard  = (r_refresh_cnt == {REF_W{1'b0}});
    // Slots 2/3 hold the minutes pair and slots 0/1 hold the seconds pair.
    // select=1 blanks the seconds pair and select=0 blanks the minutes pair.
    w_blank  = w_adj_on && r_blink_phase && (select ? ~r_slot[1] : r_slot[1]);

    if (w_guard || w_blank) begin
      w_seg_nxt = 7'b1111111;
      w_dp_nxt  = 1'b1;
      w_an_nxt  = 4'b1111;
    end else begin
      w_seg_nxt = bcd_to_seg(w_digit);
      w_dp_nxt  = w_dp_sel;
      w_an_nxt  = w_an_sel;
    end
  end

  // Output registers; reset turns every digit and segment off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed testbench for seg_display_mux using REFRESH_DIV=4 and BLINK_DIV=16.
// One scan frame is 16 cycles, so it lines up exactly with one blink half-period.
module tb_seg_display_mux;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [3:0] sec1, sec0, min1, min0;
  logic [1:0] adj;
  logic       select;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int n_chk;
  int n_fail;

  logic [3:0] exp_an  [4];
  logic [6:0] exp_seg [4];

  seg_display_mux #(
    .REFRESH_DIV(4),
    .BLINK_DIV  (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sec1  (sec1),
    .sec0  (sec0),
    .min1  (min1),
    .min0  (min0),
    .adj   (adj),
    .select(select),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] a_obs, input logic [6:0] s_obs, input logic d_obs,
                     input logic [3:0] a_exp, input logic [6:0] s_exp, input logic d_exp);
    n_chk++;
    assert ({a_obs, s_obs, d_obs} === {a_exp, s_exp, d_exp})
    else begin
      n_fail++;
      $error("FAIL %s t=%0t: observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
             tag, $time, a_obs, s_obs, d_obs, a_exp, s_exp, d_exp);
    end
  endtask

  // Checks one full 16-cycle frame that starts at the slot0 guard cycle.
  // A set bit in blank marks a slot expected to be blanked by the blink.
  task automatic check_frame(input string tag, input logic [3:0] blank);
    for (int s = 0; s < 4; s++) begin
      cyc();
      chk({tag, "_guard"}, an, seg, dp, 4'b1111, SEG_OFF, 1'b1);
      for (int k = 0; k < 3; k++) begin
        cyc();
        if (blank[s])
          chk({tag, "_blank"}, an, seg, dp, 4'b1111, SEG_OFF, 1'b1);
        else
          chk({tag, "_lit"}, an, seg, dp, exp_an[s], exp_seg[s], (s == 2) ? 1'b0 : 1'b1);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_an[0] = 4'b1110;
    exp_an[1] = 4'b1101;
    exp_an[2] = 4'b1011;
    exp_an[3] = 4'b0111;

    rst = 1'b1; adj = 2'b00; select = 1'b0;
    min0 = 4'd1; min1 = 4'd2; sec0 = 4'd3; sec1 = 4'd4;
    cyc();
    chk("reset", an, seg, dp, 4'b1111, SEG_OFF, 1'b1);
    rst = 1'b0;

    // Plain scan of 12:34.
    exp_seg[0] = SEG_4; exp_seg[1] = SEG_3; exp_seg[2] = SEG_2; exp_seg[3] = SEG_1;
    check_frame("scan1234", 4'b0000);

    // Assert asynchronous reset while slot2 is lit.
    repeat (9) cyc();
    cyc();
    chk("slot2_before_rst", an, seg, dp, 4'b1011, SEG_2, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst", an, seg, dp, 4'b1111, SEG_OFF, 1'b1);
    cyc();
    rst = 1'b0;
    check_frame("after_rst", 4'b0000);

    // Invalid BCD in sec1 shows a dash.
    sec1 = 4'hC; sec0 = 4'd0; min1 = 4'd0; min0 = 4'd0;
    exp_seg[0] = SEG_DASH; exp_seg[1] = SEG_0; exp_seg[2] = SEG_0; exp_seg[3] = SEG_0;
    check_frame("bad_bcd", 4'b0000);

    // Change a digit while slot2 is active; the change shows on the next slot0.
    min0 = 4'd1; min1 = 4'd2; sec0 = 4'd3; sec1 = 4'd4;
    repeat (9) cyc();
    cyc();
    chk("slot2_pre_update", an, seg, dp, 4'b1011, SEG_2, 1'b0);
    sec1 = 4'd5;
    repeat (6) cyc();
    exp_seg[0] = SEG_5; exp_seg[1] = SEG_3; exp_seg[2] = SEG_2; exp_seg[3] = SEG_1;
    check_frame("digit_update", 4'b0000);

    // Blink with the seconds pair selected, then move it to the minutes pair.
    adj = 2'b01; select = 1'b1;
    check_frame("blk_sec_vis", 4'b0000);
    check_frame("blk_sec_blank", 4'b0011);
    check_frame("blk_sec_vis2", 4'b0000);
    select = 1'b0;
    check_frame("blk_min_blank", 4'b1100);
    check_frame("blk_min_vis", 4'b0000);

    // Leave adjust mode while slot2 is blanked.
    repeat (9) cyc();
    cyc();
    chk("blank_slot2", an, seg, dp, 4'b1111, SEG_OFF, 1'b1);
    adj = 2'b00;
    cyc();
    chk("adj_off_restore", an, seg, dp, 4'b1011, SEG_2, 1'b0);
    repeat (5) cyc();
    check_frame("adj_off_frame", 4'b0000);

    // Re-entering adjust starts with a full visible half-period.
    adj = 2'b10;
    check_frame("reenter_vis", 4'b0000);
    check_frame("reenter_blank", 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
